stream_demux_n: RTL

- Registered 1-to-NUM_OUTPUTS stream distributor; inverse of the N-to-1 operand mux.
- Takes one valid/ready input word and routes it to one output lane.
- The lane is chosen by an explicit select or by an internal round-robin pointer.
- Used to fan neuron/synapse words out to parallel lanes; packed output layout matches the mux input packing (lane 0 in LSBs).

---
 rtl/dnn_mux_pkg.sv | 12 +
 rtl/stream_demux_lane.sv | 27 ++
 rtl/stream_demux_n.sv | 57 +++++
 3 files changed

// File: rtl/dnn_mux_pkg.sv
// Shared constants and helpers for the DNN operand mux / demux pair.
package dnn_mux_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_SEL_WIDTH = 1;

    // Bit offset of lane k inside a packed lane bus (lane 0 in the LSBs).
    function automatic int lane_offset(input int k, input int bit_width);
        return k * bit_width;
    endfunction

endpackage

// File: rtl/stream_demux_lane.sv
// Single-entry lane holding register: load wins over drain, holds while stalled.
module stream_demux_lane #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [BIT_WIDTH-1:0] i_data,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [BIT_WIDTH-1:0] o_data
);

    // Refill on the drain edge keeps valid high, so a lane can stream 1 word/cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream distributor with select or round-robin lane choice.
module stream_demux_n
    import dnn_mux_pkg::*;
#(
    parameter  int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter  int SEL_WIDTH   = DEF_SEL_WIDTH,
    localparam int NUM_OUTPUTS = 1 << SEL_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [BIT_WIDTH-1:0]             i_data,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [SEL_WIDTH-1:0]             i_sel,
    input  logic                             i_rr_mode,
    output logic [NUM_OUTPUTS*BIT_WIDTH-1:0] o_outputs,
    output logic [NUM_OUTPUTS-1:0]           o_valid,
    input  logic [NUM_OUTPUTS-1:0]           i_ready,
    output logic [SEL_WIDTH-1:0]             o_rr_ptr
);

    logic [SEL_WIDTH-1:0]   tgt;
    logic                   accept;
    logic [NUM_OUTPUTS-1:0] load;

    // Target decode and upstream ready; the target lane may drain and refill on one edge.
    always_comb begin
        tgt     = i_rr_mode ? o_rr_ptr : i_sel;
        o_ready = !o_valid[tgt] || i_ready[tgt];
        accept  = i_valid && o_ready;
    end

    // Pointer only advances on accepted round-robin words, so a stall never skips a lane.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_rr_ptr <= '0;
        else if (accept && i_rr_mode)
            o_rr_ptr <= o_rr_ptr + 1'b1;
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
        localparam logic [SEL_WIDTH-1:0] LANE = SEL_WIDTH'(k);

        assign load[k] = accept && (tgt == LANE);

        stream_demux_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (load[k]),
            .i_data  (i_data),
            .i_ready (i_ready[k]),
            .o_valid (o_valid[k]),
            .o_data  (o_outputs[lane_offset(k, BIT_WIDTH) +: BIT_WIDTH])
        );
    end

endmodule
